// File: rtl/gates_sweep_checker_if.sv
// Result channel between the sweep checker and its consumer.
// Handshake: a word transfers on the rising edge where res_valid and res_ready
// are both high; res_valid/res_data stay stable until that transfer happens,
// and res_ready may be driven freely by the consumer.
interface gates_sweep_checker_if;
   logic       res_valid;
   logic       res_ready;
   logic [4:0] res_data;

   modport master (output res_valid, output res_data, input res_ready);
   modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/gates_sweep_checker.sv
// Drives all four input vectors into a two-input gates cell NUM_SWEEPS times,
// checks out1 = in1 & in2 and out2 = in1 | in2, and queues one result word
// {vec, out1, out2, err} per vector into a first-word-fall-through FIFO.
module gates_sweep_checker #(
   parameter int NUM_SWEEPS = 4,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                drv_in1,
   output logic                drv_in2,
   input  logic                cap_out1,
   input  logic                cap_out2,
   gates_sweep_checker_if.master res,
   output logic [CNT_W-1:0]    err_cnt,
   output logic                busy,
   output logic                done,
   output logic [2:0]          dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SAMPLE = 3'd2,
      S_PUSH   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_FW = PTR_W + 1;
   localparam int SW_W = (NUM_SWEEPS > 1) ? $clog2(NUM_SWEEPS) : 1;
   localparam logic [SW_W-1:0]   LAST_SWEEP = SW_W'(NUM_SWEEPS - 1);
   localparam logic [CNT_FW-1:0] FULL_CNT   = CNT_FW'(FIFO_DEPTH);

   state_t            state_q, state_d;
   logic [1:0]        vec_q, vec_d;
   logic [SW_W-1:0]   sweep_q, sweep_d;
   logic              drv1_q, drv1_d, drv2_q, drv2_d;
   logic              cap1_q, cap1_d, cap2_q, cap2_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

   logic [4:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_FW-1:0] count_q;
   logic              push, pop, full;

   assign full = (count_q == FULL_CNT);
   assign pop  = (count_q != '0) && res.res_ready;

   // Next-state and datapath: one FSM step per edge; PUSH stalls while the FIFO is full.
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      sweep_d   = sweep_q;
      drv1_d    = drv1_q;
      drv2_d    = drv2_q;
      cap1_d    = cap1_q;
      cap2_d    = cap2_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      push      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               drv1_d = 1'b0;
               drv2_d = 1'b0;
            end
            if (start) begin
               state_d   = S_DRIVE;
               vec_d     = 2'd0;
               sweep_d   = '0;
               err_cnt_d = '0;
               drv1_d    = 1'b0;
               drv2_d    = 1'b0;
            end
         end
         S_DRIVE: state_d = S_SAMPLE;
         S_SAMPLE: begin
            cap1_d  = cap_out1;
            cap2_d  = cap_out2;
            err_d   = (cap_out1 != (vec_q[1] & vec_q[0])) |
                      (cap_out2 != (vec_q[1] | vec_q[0]));
            state_d = S_PUSH;
         end
         S_PUSH: begin
            if (!full) begin
               push = 1'b1;
               if (err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
               if (vec_q != 2'd3) begin
                  vec_d   = vec_q + 2'd1;
                  state_d = S_DRIVE;
               end else if (sweep_q != LAST_SWEEP) begin
                  sweep_d = sweep_q + SW_W'(1);
                  vec_d   = 2'd0;
                  state_d = S_DRIVE;
               end else begin
                  state_d = S_DONE;
               end
               // Outputs settle to the new vector at the same edge; zero once the run ends.
               drv1_d = (state_d == S_DONE) ? 1'b0 : vec_d[1];
               drv2_d = (state_d == S_DONE) ? 1'b0 : vec_d[0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state and sweep datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         vec_q     <= 2'd0;
         sweep_q   <= '0;
         drv1_q    <= 1'b0;
         drv2_q    <= 1'b0;
         cap1_q    <= 1'b0;
         cap2_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         sweep_q   <= sweep_d;
         drv1_q    <= drv1_d;
         drv2_q    <= drv2_d;
         cap1_q    <= cap1_d;
         cap2_q    <= cap2_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Result FIFO: push gated by the registered count only, so a full FIFO never reuses a slot popped this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 5'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {vec_q, cap1_q, cap2_q, err_q};
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_FW'(1);
            2'b01:   count_q <= count_q - CNT_FW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign drv_in1       = drv1_q;
   assign drv_in2       = drv2_q;
   assign res.res_valid = (count_q != '0);
   assign res.res_data  = mem_q[rd_ptr_q];
   assign err_cnt       = err_cnt_q;
   assign busy          = (state_q == S_DRIVE) || (state_q == S_SAMPLE) || (state_q == S_PUSH);
   assign done          = (state_q == S_DONE) && (count_q == '0);
   assign dbg_state     = state_q;

endmodule
